sdram_bus_bridge: RTL

Parametrised bridge between the core's SDRAM bus port (stb/we/sel/adr/ack) and the `sdram_top` controller's level-request/ack interface. Replaces the fixed board-level glue: generates the delayed controller reset, registers byte masks and address/data at request capture, and adds a programmable ack delay. New behaviour: an init-done gate, a controller-timeout watchdog with bus error, and clean abort/drain when the bus drops stb mid-transaction. Instantiated once per board top, between `topboard` and `sdram_top`.

---
 rtl/sdram_bus_if.sv | 17 +
 rtl/sdram_bus_bridge.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sdram_bus_if.sv
// Core-side SDRAM bus port. The strobe is a level that the core holds until it sees ack or err.
interface sdram_bus_if #(
  parameter int unsigned AW = 21,
  parameter int unsigned DW = 16
);
  logic              stb;
  logic              we;
  logic [DW/8-1:0]   sel;
  logic [AW-1:0]     adr;
  logic [DW-1:0]     wdat;
  logic [DW-1:0]     rdat;
  logic              ack;
  logic              err;

  modport master (output stb, we, sel, adr, wdat, input rdat, ack, err);
  modport slave  (input stb, we, sel, adr, wdat, output rdat, ack, err);
endinterface

// File: rtl/sdram_bus_bridge.sv
// Bridges the core SDRAM bus to the sdram_top level-request/ack controller interface.
// It also sequences the controller reset, delays the bus ack and raises a bus error on controller timeout.
module sdram_bus_bridge #(
  parameter int unsigned AW        = 21,
  parameter int unsigned DW        = 16,
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned RST_DELAY = 3,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            sys_reset,
  sdram_bus_if.slave      bus,
  output logic            ctl_rst_n,
  output logic            ctl_wr_req,
  output logic            ctl_rd_req,
  input  logic            ctl_wr_ack,
  input  logic            ctl_rd_ack,
  output logic [AW:0]     ctl_addr,
  output logic [DW-1:0]   ctl_wdata,
  input  logic [DW-1:0]   ctl_rdata,
  input  logic            ctl_init_done,
  output logic [DW/8-1:0] dqm,
  output logic            busy
);
  localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, DELAY, HOLD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2;
  logic [3:0]      rst_cnt;
  logic [3:0]      dly_cnt;
  logic [WDW-1:0]  wd_cnt, wd_next;
  logic            we_q, done_flag, err_flag;
  logic [DW-1:0]   read_data;
  logic            ack_hit, wd_expire, capture;

  // sys_reset is asynchronous to clk_p; the counter only runs once the synchronised value is low.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rst_cnt   <= '0;
      ctl_rst_n <= 1'b0;
    end else begin
      sync1 <= sys_reset;
      sync2 <= sync1;
      if (sync2) begin
        rst_cnt   <= '0;
        ctl_rst_n <= 1'b0;
      end else if (rst_cnt != 4'(RST_DELAY)) begin
        rst_cnt <= rst_cnt + 4'd1;
      end else begin
        ctl_rst_n <= 1'b1;
      end
    end
  end

  assign ack_hit   = we_q ? ctl_wr_ack : ctl_rd_ack;
  assign wd_next   = wd_cnt + WDW'(1);
  assign wd_expire = (TIMEOUT != 0) && (wd_next == WDW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:
        if (bus.stb && ctl_init_done && ctl_rst_n) begin
          capture   = 1'b1;
          state_nxt = REQ;
        end
      REQ:
        if (ack_hit)        state_nxt = bus.stb ? DELAY : IDLE;
        else if (wd_expire) state_nxt = bus.stb ? HOLD : IDLE;
        else if (!bus.stb)  state_nxt = DRAIN;
      DELAY:
        if (!bus.stb)            state_nxt = IDLE;
        else if (dly_cnt == '0)  state_nxt = HOLD;
      HOLD:
        if (!bus.stb) state_nxt = IDLE;
      DRAIN:
        if (ack_hit || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (sync2) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      dqm       <= '0;
      we_q      <= 1'b0;
      wd_cnt    <= '0;
      dly_cnt   <= '0;
      read_data <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      if (capture) begin
        ctl_addr  <= {1'b0, bus.adr};
        ctl_wdata <= bus.wdat;
        dqm       <= bus.we ? ~bus.sel : '0;
        we_q      <= bus.we;
        wd_cnt    <= '0;
      end else if (state == REQ || state == DRAIN) begin
        wd_cnt <= wd_next;
      end
      if (state == REQ && ack_hit && !we_q) read_data <= ctl_rdata;
      if (state == REQ && ack_hit)                    dly_cnt <= 4'(ACK_DELAY - 1);
      else if (state == DELAY && dly_cnt != '0)       dly_cnt <= dly_cnt - 4'd1;
      // Flags live only while in HOLD; the state they came from tells done from timeout.
      if (state_nxt != HOLD) begin
        done_flag <= 1'b0;
        err_flag  <= 1'b0;
      end else if (state == DELAY) begin
        done_flag <= 1'b1;
      end else if (state == REQ) begin
        err_flag <= 1'b1;
      end
    end
  end

  assign ctl_wr_req = (state == REQ || state == DRAIN) && we_q;
  assign ctl_rd_req = (state == REQ || state == DRAIN) && !we_q;
  assign busy       = (state != IDLE);
  assign bus.ack    = done_flag && bus.stb;
  assign bus.err    = err_flag && bus.stb;
  assign bus.rdat   = read_data;
endmodule
